// File: rtl/dac8728_reg_reader.sv
// DAC8728 register read-back driver: one rd request runs a single read bus cycle and captures the returned word.
// Optional DAC8728_READ_VERIFY_EN adds a double-sample check of the bus reported on rd_err.
module dac8728_reg_reader #(
  parameter int CS_CYCLES   = 3,
  parameter int TURN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  add_in,
  input  logic        rd,
  input  logic [15:0] dac_data_in,
  output logic        done,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        rd_err,
  output logic        dac_re_wr,
  output logic        dac_cs_n,
  output logic [4:0]  dac_add,
  output logic        dac_data_oe
);

  localparam logic [3:0] CS_LOAD   = 4'(CS_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [4:0] PARK_ADD  = 5'b00111;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic [15:0] data_out_reg, data_out_next;
  logic        valid_reg, valid_next;
  logic        cs_n_reg, cs_n_next;
  logic [4:0]  add_reg, add_next;
  logic        oe_reg, oe_next;

`ifdef DAC8728_READ_VERIFY_EN
  logic [15:0] early_reg, early_next;
  logic        err_reg, err_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      done_reg     <= 1'b1;
      data_out_reg <= 16'h0000;
      valid_reg    <= 1'b0;
      cs_n_reg     <= 1'b1;
      add_reg      <= PARK_ADD;
      oe_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
      cs_n_reg     <= cs_n_next;
      add_reg      <= add_next;
      oe_reg       <= oe_next;
    end
  end

`ifdef DAC8728_READ_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      early_reg <= 16'h0000;
      err_reg   <= 1'b0;
    end else begin
      early_reg <= early_next;
      err_reg   <= err_next;
    end
  end
`endif

  // Outputs are computed alongside the transition so each lands on the edge that changes state.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    done_next     = done_reg;
    data_out_next = data_out_reg;
    valid_next    = 1'b0;
    cs_n_next     = cs_n_reg;
    add_next      = add_reg;
    oe_next       = oe_reg;
`ifdef DAC8728_READ_VERIFY_EN
    early_next    = early_reg;
    err_next      = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (rd) begin
          state_next = SETUP;
          add_next   = add_in;
          done_next  = 1'b0;
          oe_next    = 1'b0;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = CS_LOAD;
        cs_n_next  = 1'b0;
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next    = TURN;
          cnt_next      = TURN_LOAD;
          cs_n_next     = 1'b1;
          data_out_next = dac_data_in;
          valid_next    = 1'b1;
`ifdef DAC8728_READ_VERIFY_EN
          err_next      = (early_reg != dac_data_in);
`endif
        end else begin
          cnt_next = cnt_reg - 4'd1;
`ifdef DAC8728_READ_VERIFY_EN
          // One edge before capture.
          if (cnt_reg == 4'd1) early_next = dac_data_in;
`endif
        end
      end
      TURN: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
          oe_next    = 1'b1;
          add_next   = PARK_ADD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign done        = done_reg;
  assign data_out    = data_out_reg;
  assign data_valid  = valid_reg;
  assign dac_re_wr   = 1'b1;
  assign dac_cs_n    = cs_n_reg;
  assign dac_add     = add_reg;
  assign dac_data_oe = oe_reg;
`ifdef DAC8728_READ_VERIFY_EN
  assign rd_err      = err_reg;
`else
  assign rd_err      = 1'b0;
`endif

endmodule

// File: doc/dac8728_reg_reader.md
# dac8728_reg_reader

Register read-back driver for the DAC8728 parallel interface: on a single `rd` request it runs one read bus cycle (R/W high, CS low), releases the FPGA's drive of the shared 16-bit data bus, captures the word the DAC returns, and then hands the bus back. It sits beside the DAC8728 write driver on the same DAC pins, under the same bus arbiter, in the 10 MHz DAC clock domain. Its uses are configuration read-back, power-on self-check and status polling.

## Interface
Parameters:
- `CS_CYCLES`, default 3: number of clock cycles `dac_cs_n` is held low (legal range 1..15).
- `TURN_CYCLES`, default 2: bus turnaround cycles after `dac_cs_n` rises and before the FPGA drives the bus again (legal range 1..15).

Ports:
- `clk`  in  1  driver work clock, 10 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `add_in`  in  5  register address to read; latched when the request is accepted.
- `rd`  in  1  read request, sampled only in IDLE.
- `dac_data_in`  in  16  data bus input from the pad.
- `done`  out  1  1 = idle/finished, 0 = read in progress.
- `data_out`  out  16  last captured word.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `rd_err`  out  1  double-sample mismatch flag (see Configuration).
- `dac_re_wr`  out  1  DAC R/W pin.
- `dac_cs_n`  out  1  DAC chip select, active low.
- `dac_add`  out  5  DAC address pins.
- `dac_data_oe`  out  1  FPGA data-bus output enable (1 = FPGA drives, 0 = released to the DAC).

## Operation
- All outputs are registered. Reset values: `done`=1, `data_out`=16'h0000, `data_valid`=0, `rd_err`=0, `dac_re_wr`=1, `dac_cs_n`=1, `dac_add`=5'b00111, `dac_data_oe`=1.
- FSM states and transitions:
  - IDLE: moves to SETUP when `rd`=1.
  - SETUP: lasts 1 cycle, then moves to ACCESS.
  - ACCESS: lasts `CS_CYCLES` cycles, then moves to TURN.
  - TURN: lasts `TURN_CYCLES` cycles, then moves to IDLE.
  - Cycles are counted with one 4-bit down-counter that is reloaded on each state entry.
- On accepting a request:
  - `add_in` is latched internally.
  - `dac_add` holds the latched address from SETUP through TURN; later changes on `add_in` are ignored.
- `dac_re_wr` stays 1 for the whole transaction; this block never asserts write.
- `dac_data_oe` is 0 from SETUP through TURN, so the bus is released one cycle before CS falls and stays released for `TURN_CYCLES` after CS rises.
- Capture happens at the clock edge that leaves ACCESS:
  - `data_out` takes the value of `dac_data_in`, `data_valid`=1 for that one cycle, and `dac_cs_n` returns high on the same edge.
  - `data_out` holds its value until the next capture.
- `rd` asserted while `done`=0 is ignored. Requests are not queued.
- A `rd` held high continuously starts back-to-back reads. Each read is separated by one IDLE cycle.
- Reset asserted mid-transaction: every output takes its reset value immediately (asynchronously), the FSM goes to IDLE, and no `data_valid` is issued.

## Timing
Edge 0 is the rising edge at which `rd`=1 is sampled in IDLE. Values are given as "after edge n".
- Edge 0: `done`=0, `dac_add`=latched address, `dac_data_oe`=0.
- Edge 1: `dac_cs_n`=0.
- Edge 1+`CS_CYCLES`: `dac_cs_n`=1, `data_out` updated, `data_valid`=1.
- Edge 2+`CS_CYCLES`: `data_valid`=0.
- Edge 1+`CS_CYCLES`+`TURN_CYCLES`: `done`=1, `dac_data_oe`=1, `dac_add`=5'b00111.
- With defaults:
  - CS is low for 3 cycles (300 ns of access time at 10 MHz).
  - `done` is low for 6 cycles.
  - The next `rd` is sampled at edge 7 at the earliest.
- Latency from `rd` to `data_valid`: `CS_CYCLES`+1 cycles.

## Configuration
- Macro: `DAC8728_READ_VERIFY_EN`.
- Defined:
  - `dac_data_in` is also sampled one edge earlier (edge `CS_CYCLES`).
  - At capture, `rd_err` = (earlier sample != final sample). It is registered and is updated only with `data_valid`.
  - Requires `CS_CYCLES` >= 2.
- Undefined: no second sample register is present, and `rd_err` is constant 0.

## Test plan
- Reset then idle, with `rd`=0 for 20 cycles:
  - Required: all outputs hold their reset values.
  - Required: `dac_add`=5'b00111, `dac_cs_n`=1, `dac_data_oe`=1.
- Single read, `add_in`=5'h0A, DAC model returns 16'h5A3C while CS is low, defaults:
  - Required: `dac_cs_n` low for exactly 3 cycles and `dac_re_wr`=1 throughout.
  - Required: `data_out`=16'h5A3C with `data_valid` high for 1 cycle at edge 4.
  - Required: `done` rises at edge 6.
- `add_in` changed to 5'h1F at edge 2, and `rd` pulsed again at edge 3 while busy:
  - Required: `dac_add` stays 5'h0A.
  - Required: the second request is dropped and no second CS pulse occurs.
- `rd` held high for 20 cycles, with the model returning 16'h0001, 16'h0002, …:
  - Required: successive reads 7 cycles apart.
  - Required: `data_out` shows the incrementing values.
  - Required: `dac_data_oe`=0 always spans `dac_cs_n`=0 by 1 cycle before and 2 cycles after.
- `rst` asserted at edge 2 of a read:
  - Required: outputs return to reset values immediately and no `data_valid` is issued.
  - Required: after release, a new read completes normally.
- With `DAC8728_READ_VERIFY_EN` defined, the model changes the bus from 16'h1234 to 16'h1235 at edge 3:
  - Required: `rd_err`=1 together with `data_valid`.
  - Required: a following stable read clears `rd_err` to 0.
